// File: rtl/vdp_super_vram_arbiter.sv
// vdp_super_vram_arbiter
//   Slot arbiter for the single 32-bit VRAM port in super-res/super-mid modes.
//   Each scanline is split into 4-clock slots keyed on cx[1:0]. At every slot
//   boundary (sampled cx[1:0]==0) the slot goes to refresh, display fetch,
//   CPU or command engine, and that owner holds the bus for the whole slot.
//
// Ports
//   clk, reset            pixel clock, synchronous active-high reset
//   cx                    horizontal dot counter
//   vdp_super, drawing    super mode enable and display fetch window
//   disp_addr             display fetch word address
//   cpu_* / cmd_*         byte-wide requester ports (req/wr/addr/wdata in,
//                         ack/rdata out)
//   mem_*                 registered VRAM address/control/write-data bus
//   mem_rdata             VRAM read data, valid at the last phase of the slot
//   owner                 current slot owner (0 idle, 1 refresh, 2 disp,
//                         3 cpu, 4 cmd)
//
// Optional build macro VDP_SUPER_ARB_STALL_COUNT_EN adds cpu_stall_count
// (boundaries where the CPU wanted the bus but did not get it) and stall_clear.
module vdp_super_vram_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int REFRESH_X = 723
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        cx,
  input  logic              vdp_super,
  input  logic              drawing,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              cmd_req,
  input  logic              cmd_wr,
  input  logic [ADDR_W+1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              cmd_ack,
  output logic [7:0]        cmd_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  output logic              mem_refresh,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        owner
`ifdef VDP_SUPER_ARB_STALL_COUNT_EN
  ,
  output logic [15:0]       cpu_stall_count,
  input  logic              stall_clear
`endif
);

  // state    | meaning
  // OWN_IDLE | nobody uses the slot, bus driven to 0
  // OWN_REF  | SDRAM refresh slot
  // OWN_DISP | super-res display fetch
  // OWN_CPU  | CPU byte access
  // OWN_CMD  | command engine byte access
  typedef enum logic [2:0] {
    OWN_IDLE = 3'd0,
    OWN_REF  = 3'd1,
    OWN_DISP = 3'd2,
    OWN_CPU  = 3'd3,
    OWN_CMD  = 3'd4
  } owner_t;

  localparam logic [9:0] REFRESH_CX = 10'(REFRESH_X);

  owner_t            state, owner_sel;
  logic              rr_cmd, rr_cmd_nx;
  logic [1:0]        slot_lane, slot_lane_nx;
  logic              slot_wr, slot_wr_nx;
  logic              boundary, complete;
  logic              cpu_req_eff, cmd_req_eff;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic              mem_cs_nx, mem_wr_nx, mem_refresh_nx;
  logic [3:0]        mem_be_nx;
  logic [31:0]       mem_wdata_nx;
  logic [7:0]        lane_data;

  assign owner = state;

  // Completion lands in the boundary cycle, and the requester only drops req
  // the cycle after ack, so req is masked while its own ack is high; otherwise
  // every access would be served twice.
  assign cpu_req_eff = cpu_req & ~cpu_ack;
  assign cmd_req_eff = cmd_req & ~cmd_ack;
  assign boundary    = (cx[1:0] == 2'd0);
  assign complete    = (cx[1:0] == 2'd3);
  assign lane_data   = mem_rdata[8*slot_lane +: 8];

  always_comb begin
    owner_sel      = OWN_IDLE;
    rr_cmd_nx      = rr_cmd;
    slot_lane_nx   = 2'd0;
    slot_wr_nx     = 1'b0;
    mem_addr_nx    = '0;
    mem_cs_nx      = 1'b0;
    mem_wr_nx      = 1'b0;
    mem_be_nx      = 4'h0;
    mem_wdata_nx   = 32'h0;
    mem_refresh_nx = 1'b0;

    if (cx[9:2] == REFRESH_CX[9:2])
      owner_sel = OWN_REF;
    else if (drawing && vdp_super)
      owner_sel = OWN_DISP;
    else if (cpu_req_eff && cmd_req_eff)
      owner_sel = rr_cmd ? OWN_CMD : OWN_CPU;
    else if (cpu_req_eff)
      owner_sel = OWN_CPU;
    else if (cmd_req_eff)
      owner_sel = OWN_CMD;

    case (owner_sel)
      OWN_REF: mem_refresh_nx = 1'b1;
      OWN_DISP: begin
        mem_addr_nx = disp_addr;
        mem_cs_nx   = 1'b1;
        mem_be_nx   = 4'hF;
      end
      OWN_CPU: begin
        rr_cmd_nx    = 1'b1;
        slot_lane_nx = cpu_addr[1:0];
        slot_wr_nx   = cpu_wr;
        mem_addr_nx  = cpu_addr[ADDR_W+1:2];
        mem_cs_nx    = 1'b1;
        mem_wr_nx    = cpu_wr;
        mem_be_nx    = 4'b0001 << cpu_addr[1:0];
        mem_wdata_nx = {4{cpu_wdata}};
      end
      OWN_CMD: begin
        rr_cmd_nx    = 1'b0;
        slot_lane_nx = cmd_addr[1:0];
        slot_wr_nx   = cmd_wr;
        mem_addr_nx  = cmd_addr[ADDR_W+1:2];
        mem_cs_nx    = 1'b1;
        mem_wr_nx    = cmd_wr;
        mem_be_nx    = 4'b0001 << cmd_addr[1:0];
        mem_wdata_nx = {4{cmd_wdata}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= OWN_IDLE;
      rr_cmd      <= 1'b0;
      slot_lane   <= 2'd0;
      slot_wr     <= 1'b0;
      mem_addr    <= '0;
      mem_cs      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_be      <= 4'h0;
      mem_wdata   <= 32'h0;
      mem_refresh <= 1'b0;
      cpu_ack     <= 1'b0;
      cmd_ack     <= 1'b0;
      cpu_rdata   <= 8'h0;
      cmd_rdata   <= 8'h0;
    end else begin
      cpu_ack <= 1'b0;
      cmd_ack <= 1'b0;
      if (boundary) begin
        state       <= owner_sel;
        rr_cmd      <= rr_cmd_nx;
        slot_lane   <= slot_lane_nx;
        slot_wr     <= slot_wr_nx;
        mem_addr    <= mem_addr_nx;
        mem_cs      <= mem_cs_nx;
        mem_wr      <= mem_wr_nx;
        mem_be      <= mem_be_nx;
        mem_wdata   <= mem_wdata_nx;
        mem_refresh <= mem_refresh_nx;
      end else if (complete) begin
        if (state == OWN_CPU) begin
          cpu_ack <= 1'b1;
          if (!slot_wr) cpu_rdata <= lane_data;
        end
        if (state == OWN_CMD) begin
          cmd_ack <= 1'b1;
          if (!slot_wr) cmd_rdata <= lane_data;
        end
      end
    end
  end

`ifdef VDP_SUPER_ARB_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || stall_clear)
      cpu_stall_count <= 16'h0;
    else if (boundary && cpu_req_eff && owner_sel != OWN_CPU &&
             cpu_stall_count != 16'hFFFF)
      cpu_stall_count <= cpu_stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Directed bench for vdp_super_vram_arbiter. The bench owns cx and advances it
// one dot per clock, 1 time unit after each rising edge, so every check below
// sees the outputs produced by the edge that just sampled the previous cx.
module tb_vdp_super_vram_arbiter;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        cx;
  logic              vdp_super, drawing;
  logic [ADDR_W-1:0] disp_addr;
  logic              cpu_req, cpu_wr, cpu_ack;
  logic [ADDR_W+1:0] cpu_addr;
  logic [7:0]        cpu_wdata, cpu_rdata;
  logic              cmd_req, cmd_wr, cmd_ack;
  logic [ADDR_W+1:0] cmd_addr;
  logic [7:0]        cmd_wdata, cmd_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs, mem_wr, mem_refresh;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [2:0]        owner;
`ifdef VDP_SUPER_ARB_STALL_COUNT_EN
  logic [15:0]       cpu_stall_count;
  logic              stall_clear;
`endif

  int checks = 0;
  int errors = 0;

  vdp_super_vram_arbiter #(.ADDR_W(ADDR_W), .REFRESH_X(723)) dut (
    .clk(clk), .reset(reset), .cx(cx), .vdp_super(vdp_super), .drawing(drawing),
    .disp_addr(disp_addr),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_refresh(mem_refresh), .mem_rdata(mem_rdata),
    .owner(owner)
`ifdef VDP_SUPER_ARB_STALL_COUNT_EN
    , .cpu_stall_count(cpu_stall_count), .stall_clear(stall_clear)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cx = (cx == 10'd857) ? 10'd0 : cx + 10'd1;
    end
  endtask

  task automatic goto_cx(input int target);
    int guard;
    guard = 0;
    while (int'(cx) != target && guard < 1000) begin
      step();
      guard++;
    end
    checks++;
    if (int'(cx) != target) begin
      errors++;
      $error("FAIL goto_cx: observed %0d expected %0d", cx, target);
    end
  endtask

  initial begin
    reset = 1'b1; cx = 10'd0; vdp_super = 1'b0; drawing = 1'b0;
    disp_addr = '0; mem_rdata = 32'hAABBCCDD;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = 8'h00;
`ifdef VDP_SUPER_ARB_STALL_COUNT_EN
    stall_clear = 1'b0;
`endif

    // reset state
    step();
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_cs", 32'(mem_cs), 32'd0);
    check("rst_ack", 32'({cpu_ack, cmd_ack}), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, cmd_rdata}), 32'd0);
    check("rst_mem", 32'({mem_wr, mem_be, mem_refresh}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    step(2);
    reset = 1'b0;

    // CPU and CMD both requesting: alternate starting with CPU
    goto_cx(4);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00000;
    cmd_req = 1'b1; cmd_wr = 1'b0; cmd_addr = 19'h00001;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_owner", 32'(owner), (k % 2 == 0) ? 32'd3 : 32'd4);
      check("rr_ack_low", 32'({cpu_ack, cmd_ack}), 32'd0);
      step(3);
      check("rr_ack", 32'({cpu_ack, cmd_ack}), (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    cpu_req = 1'b0; cmd_req = 1'b0;
    step();
    check("rr_idle", 32'(owner), 32'd0);
    check("rr_ack_end", 32'({cpu_ack, cmd_ack}), 32'd0);

    // CPU read of byte 6 -> word 1, lane 2
    goto_cx(24);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00006;
    step();
    check("rd_owner", 32'(owner), 32'd3);
    check("rd_addr", 32'(mem_addr), 32'd1);
    check("rd_be", 32'(mem_be), 32'b0100);
    check("rd_cs_wr", 32'({mem_cs, mem_wr}), 32'b10);
    step(2);
    check("rd_ack_early", 32'(cpu_ack), 32'd0);
    step();
    check("rd_ack", 32'(cpu_ack), 32'd1);
    check("rd_rdata", 32'(cpu_rdata), 32'hBB);
    cpu_req = 1'b0;
    step();
    check("rd_ack_width", 32'(cpu_ack), 32'd0);
    check("rd_idle_bus", 32'({mem_cs, mem_be, 15'(mem_addr)}), 32'd0);
    check("rd_rdata_hold", 32'(cpu_rdata), 32'hBB);

    // display window holds off the CPU
    goto_cx(32);
    drawing = 1'b1; vdp_super = 1'b1; disp_addr = 17'h1ABCD;
    cpu_req = 1'b1; cpu_addr = 19'h00011;
    for (int k = 0; k < 3; k++) begin
      step();
      check("disp_owner", 32'(owner), 32'd2);
      check("disp_addr", 32'(mem_addr), 32'h1ABCD);
      check("disp_ctl", 32'({mem_cs, mem_wr, mem_be}), 32'b1_0_1111);
      step(3);
      check("disp_no_ack", 32'(cpu_ack), 32'd0);
    end
    drawing = 1'b0;
    step();
    check("disp_end_owner", 32'(owner), 32'd3);
    check("disp_end_addr", 32'(mem_addr), 32'd4);
    check("disp_end_be", 32'(mem_be), 32'b0010);
    step(3);
    check("disp_end_ack", 32'(cpu_ack), 32'd1);
    check("disp_end_rdata", 32'(cpu_rdata), 32'hCC);
    cpu_req = 1'b0;

    // vdp_super off: drawing ignored
    goto_cx(52);
    vdp_super = 1'b0; drawing = 1'b1; cpu_req = 1'b1;
    step();
    check("nosuper_owner", 32'(owner), 32'd3);
    step(3);
    check("nosuper_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0; drawing = 1'b0;

    // refresh slot 720..723 pre-empts the CPU
    goto_cx(720);
    cpu_req = 1'b1; cpu_addr = 19'h00006;
    step();
    check("ref_owner", 32'(owner), 32'd1);
    check("ref_flags", 32'({mem_refresh, mem_cs}), 32'b10);
    step(3);
    check("ref_no_ack", 32'(cpu_ack), 32'd0);
    step();
    check("ref_cpu_owner", 32'(owner), 32'd3);
    check("ref_cpu_refresh_low", 32'(mem_refresh), 32'd0);
    step(3);
    check("ref_cpu_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;

    // CMD write of byte 3, reset at phase 2 aborts it
    goto_cx(732);
    cmd_req = 1'b1; cmd_wr = 1'b1; cmd_addr = 19'h00003; cmd_wdata = 8'h5A;
    step();
    check("wr_owner", 32'(owner), 32'd4);
    check("wr_ctl", 32'({mem_cs, mem_wr, mem_be}), 32'b1_1_1000);
    check("wr_wdata", mem_wdata, 32'h5A5A5A5A);
    check("wr_addr", 32'(mem_addr), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("abort_owner", 32'(owner), 32'd0);
    check("abort_bus", 32'({mem_cs, mem_wr, mem_be, mem_refresh}), 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_ack", 32'(cmd_ack), 32'd0);
    reset = 1'b0; cmd_req = 1'b0;
    step();
    check("abort_no_ack", 32'(cmd_ack), 32'd0);

    // cx wrap needs nothing special
    goto_cx(0);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00007;
    step();
    check("wrap_owner", 32'(owner), 32'd3);
    check("wrap_be", 32'(mem_be), 32'b1000);
    step(3);
    check("wrap_rdata", 32'(cpu_rdata), 32'hAA);
    cpu_req = 1'b0;

`ifdef VDP_SUPER_ARB_STALL_COUNT_EN
    goto_cx(12);
    check("stall_start", 32'(cpu_stall_count), 32'd0);
    drawing = 1'b1; vdp_super = 1'b1; cpu_req = 1'b1;
    step(40);
    check("stall_count", 32'(cpu_stall_count), 32'd10);
    cpu_req = 1'b0; drawing = 1'b0; stall_clear = 1'b1;
    step();
    stall_clear = 1'b0;
    check("stall_clear", 32'(cpu_stall_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
